// File: rtl/sweep_data_parser_pkg.sv
// ============================================================================
// sweep_data_parser_pkg
// Marker constants, parser state encoding and the DAC0 bit-order helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sweep_data_parser_pkg;

  localparam logic [15:0] DEFAULT_HEADER_WORD = 16'hFFAB;
  localparam logic [15:0] DEFAULT_STEP_WORD   = 16'hFF5C;
  localparam logic [15:0] DEFAULT_TAIL_WORD   = 16'hFF5D;
  localparam logic [7:0]  MARKER_BYTE         = 8'hFF;
  localparam logic [15:0] COUNT_MAX           = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_STEP = 2'd1,
    ST_PARAM     = 2'd2,
    ST_DATA      = 2'd3
  } parser_state_t;

  // The acquisition controller ships DAC0 in SC (reversed) bit order.
  function automatic logic [9:0] dac_invert(input logic [9:0] code);
    logic [9:0] flipped;
    for (int i = 0; i < 10; i++) begin
      flipped[i] = code[9 - i];
    end
    return flipped;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sweep_data_parser_if.sv
// ============================================================================
// sweep_data_parser_if
// Stream input and per-step record output bundle of the sweep parser.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sweep_data_parser_if;
  logic [15:0] SweepData;
  logic        SweepData_en;
  logic [15:0] ExpectedCount;
  logic        ClearError;
  logic [9:0]  StepDAC0;
  logic [5:0]  StepMask;
  logic [15:0] StepCount;
  logic        StepValid;
  logic        StepCountError;
  logic [9:0]  StepIndex;
  logic        SweepDone;
  logic        FramingError;
  logic        ErrorSticky;
  logic        Busy;

  modport master (
    output SweepData, SweepData_en, ExpectedCount, ClearError,
    input  StepDAC0, StepMask, StepCount, StepValid, StepCountError,
           StepIndex, SweepDone, FramingError, ErrorSticky, Busy
  );

  modport slave (
    input  SweepData, SweepData_en, ExpectedCount, ClearError,
    output StepDAC0, StepMask, StepCount, StepValid, StepCountError,
           StepIndex, SweepDone, FramingError, ErrorSticky, Busy
  );
endinterface

`default_nettype wire

// File: rtl/sweep_step_counter.sv
// ============================================================================
// sweep_step_counter
// Saturating 16-bit data-word counter with compare against the expected count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sweep_step_counter
  import sweep_data_parser_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        incr,
  input  logic [15:0] expected,
  output logic [15:0] count,
  output logic        mismatch
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != COUNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

  assign mismatch = (count != expected);

endmodule

`default_nettype wire

// File: rtl/sweep_data_parser.sv
// ============================================================================
// sweep_data_parser
// Decodes the framed sweep stream into one registered record per DAC step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sweep_data_parser
  import sweep_data_parser_pkg::*;
#(
  parameter logic [15:0] HEADER_WORD = DEFAULT_HEADER_WORD,
  parameter logic [15:0] STEP_WORD   = DEFAULT_STEP_WORD,
  parameter logic [15:0] TAIL_WORD   = DEFAULT_TAIL_WORD
) (
  input  logic               Clk,
  input  logic               reset_n,
  sweep_data_parser_if.slave bus
);

  parser_state_t state, next_state;

  logic        is_marker, is_header, is_step, is_tail;
  logic        emit, done, ferr, latch_param, cnt_clear, cnt_incr;
  logic        idx_clear, idx_incr, header_clear;
  logic [15:0] word_count;
  logic        count_mismatch;

  logic [9:0]  dac_hold;
  logic [5:0]  mask_hold;
  logic [9:0]  step_idx;

  logic [9:0]  step_dac0_q;
  logic [5:0]  step_mask_q;
  logic [15:0] step_count_q;
  logic        step_valid_q, step_cerr_q, sweep_done_q, framing_err_q;
  logic        sticky_q, busy_q;
  logic [9:0]  step_index_q;

  assign is_marker = (bus.SweepData[15:8] == MARKER_BYTE);
  assign is_header = (bus.SweepData == HEADER_WORD);
  assign is_step   = (bus.SweepData == STEP_WORD);
  assign is_tail   = (bus.SweepData == TAIL_WORD);

  always_ff @(posedge Clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    emit         = 1'b0;
    done         = 1'b0;
    ferr         = 1'b0;
    latch_param  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_incr     = 1'b0;
    idx_clear    = 1'b0;
    idx_incr     = 1'b0;
    header_clear = 1'b0;
    if (bus.SweepData_en) begin
      case (state)
        ST_IDLE: begin
          if (is_header) begin
            next_state   = ST_WAIT_STEP;
            idx_clear    = 1'b1;
            header_clear = 1'b1;
          end
        end
        ST_WAIT_STEP: begin
          if (is_step) begin
            next_state = ST_PARAM;
          end else if (is_tail) begin
            done       = 1'b1;
            next_state = ST_IDLE;
          end else begin
            ferr       = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_PARAM: begin
          if (!is_marker) begin
            latch_param = 1'b1;
            cnt_clear   = 1'b1;
            next_state  = ST_DATA;
          end else begin
            ferr       = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!is_marker) begin
            cnt_incr = 1'b1;
          end else if (is_step) begin
            emit       = 1'b1;
            idx_incr   = 1'b1;
            next_state = ST_PARAM;
          end else if (is_tail) begin
            emit       = 1'b1;
            done       = 1'b1;
            next_state = ST_IDLE;
          end else begin
            ferr       = 1'b1;
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  sweep_step_counter u_step_counter (
    .clk      (Clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .incr     (cnt_incr),
    .expected (bus.ExpectedCount),
    .count    (word_count),
    .mismatch (count_mismatch)
  );

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      dac_hold      <= '0;
      mask_hold     <= '0;
      step_idx      <= '0;
      step_dac0_q   <= '0;
      step_mask_q   <= '0;
      step_count_q  <= '0;
      step_cerr_q   <= 1'b0;
      step_index_q  <= '0;
      step_valid_q  <= 1'b0;
      sweep_done_q  <= 1'b0;
      framing_err_q <= 1'b0;
      sticky_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      step_valid_q  <= emit;
      sweep_done_q  <= done;
      framing_err_q <= ferr;
      busy_q        <= (next_state != ST_IDLE);
      if (latch_param) begin
        dac_hold  <= dac_invert(bus.SweepData[9:0]);
        mask_hold <= bus.SweepData[15:10];
      end
      if (emit) begin
        step_dac0_q  <= dac_hold;
        step_mask_q  <= mask_hold;
        step_count_q <= word_count;
        step_cerr_q  <= count_mismatch;
        step_index_q <= step_idx;
      end
      if (idx_clear)     step_idx <= '0;
      else if (idx_incr) step_idx <= step_idx + 10'd1;
      // A new error in the same cycle as a clear must stay visible.
      if (ferr || (emit && count_mismatch)) sticky_q <= 1'b1;
      else if (bus.ClearError || header_clear) sticky_q <= 1'b0;
    end
  end

  assign bus.StepDAC0       = step_dac0_q;
  assign bus.StepMask       = step_mask_q;
  assign bus.StepCount      = step_count_q;
  assign bus.StepValid      = step_valid_q;
  assign bus.StepCountError = step_cerr_q;
  assign bus.StepIndex      = step_index_q;
  assign bus.SweepDone      = sweep_done_q;
  assign bus.FramingError   = framing_err_q;
  assign bus.ErrorSticky    = sticky_q;
  assign bus.Busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_data_parser.sv
// ============================================================================
// tb_sweep_data_parser
// Directed self-checking bench for the sweep stream parser.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sweep_data_parser;

  localparam logic [15:0] HDR  = 16'hFFAB;
  localparam logic [15:0] STP  = 16'hFF5C;
  localparam logic [15:0] TL   = 16'hFF5D;

  logic Clk;
  logic reset_n;

  sweep_data_parser_if bus ();

  sweep_data_parser dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  dac;
    logic [5:0]  mask;
    logic [15:0] cnt;
    logic        cerr;
    logic [9:0]  idx;
  } rec_t;

  rec_t rec_q[$];
  int   n_done, n_ferr;
  int   run_v, run_d, run_f, max_v, max_d, max_f;
  int   checks, errors;

  // Param words {mask, SC-order DAC0}: DAC 100/101/102 reversed are 0x098/0x298/0x198.
  logic [15:0] sweep_params [3];
  logic [9:0]  sweep_dacs   [3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    n_done = 0; n_ferr = 0;
    run_v = 0; run_d = 0; run_f = 0;
    max_v = 0; max_d = 0; max_f = 0;
    forever begin
      @(negedge Clk);
      if (bus.StepValid) begin
        rec_q.push_back({bus.StepDAC0, bus.StepMask, bus.StepCount,
                         bus.StepCountError, bus.StepIndex});
        run_v++;
        if (run_v > max_v) max_v = run_v;
      end else run_v = 0;
      if (bus.SweepDone) begin
        n_done++;
        run_d++;
        if (run_d > max_d) max_d = run_d;
      end else run_d = 0;
      if (bus.FramingError) begin
        n_ferr++;
        run_f++;
        if (run_f > max_f) max_f = run_f;
      end else run_f = 0;
    end
  end

  task automatic send(input logic [15:0] w, input bit gapped);
    int k;
    k = gapped ? int'($urandom_range(0, 2)) : 0;
    @(negedge Clk);
    for (int j = 0; j < k; j++) begin
      bus.SweepData_en = 1'b0;
      bus.SweepData    = HDR;
      @(negedge Clk);
    end
    bus.SweepData    = w;
    bus.SweepData_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      bus.SweepData_en = 1'b0;
      bus.SweepData    = 16'h0000;
    end
  endtask

  task automatic clean_sweep(input string tag, input bit gapped);
    int base, d0, f0;
    base = rec_q.size();
    d0 = n_done;
    f0 = n_ferr;
    bus.ExpectedCount = 16'd4;
    send(HDR, gapped);
    for (int s = 0; s < 3; s++) begin
      send(STP, gapped);
      send(sweep_params[s], gapped);
      for (int i = 0; i < 4; i++) send(16'(16'h0100 * s + i), gapped);
    end
    send(TL, gapped);
    idle(4);
    check_eq({tag, "_nrec"}, 64'(rec_q.size() - base), 64'd3);
    for (int s = 0; s < 3; s++) begin
      if (rec_q.size() > base + s) begin
        check_eq({tag, "_dac"},  64'(rec_q[base+s].dac),  64'(sweep_dacs[s]));
        check_eq({tag, "_mask"}, 64'(rec_q[base+s].mask), 64'(s + 1));
        check_eq({tag, "_cnt"},  64'(rec_q[base+s].cnt),  64'd4);
        check_eq({tag, "_cerr"}, 64'(rec_q[base+s].cerr), 64'd0);
        check_eq({tag, "_idx"},  64'(rec_q[base+s].idx),  64'(s));
      end
    end
    check_eq({tag, "_done"},   64'(n_done - d0), 64'd1);
    check_eq({tag, "_ferr"},   64'(n_ferr - f0), 64'd0);
    check_eq({tag, "_sticky"}, 64'(bus.ErrorSticky), 64'd0);
    check_eq({tag, "_busy"},   64'(bus.Busy), 64'd0);
  endtask

  initial begin
    int base, f0;
    checks = 0;
    errors = 0;
    sweep_params[0] = 16'h0498; sweep_dacs[0] = 10'd100;
    sweep_params[1] = 16'h0A98; sweep_dacs[1] = 10'd101;
    sweep_params[2] = 16'h0D98; sweep_dacs[2] = 10'd102;

    reset_n           = 1'b0;
    bus.SweepData     = 16'h0000;
    bus.SweepData_en  = 1'b0;
    bus.ExpectedCount = 16'd4;
    bus.ClearError    = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("reset_outputs",
             64'({bus.StepDAC0, bus.StepMask, bus.StepCount, bus.StepValid,
                  bus.StepCountError, bus.StepIndex, bus.SweepDone,
                  bus.FramingError, bus.ErrorSticky, bus.Busy}), 64'd0);
    reset_n = 1'b1;

    clean_sweep("clean", 1'b0);
    clean_sweep("gapped", 1'b1);

    // Bit reverse and count mismatch: 3 words against an expected 4.
    base = rec_q.size();
    send(HDR, 1'b0);
    send(STP, 1'b0);
    send(16'hFC01, 1'b0);
    for (int i = 0; i < 3; i++) send(16'(16'h0010 + i), 1'b0);
    send(TL, 1'b0);
    idle(3);
    check_eq("mm_nrec", 64'(rec_q.size() - base), 64'd1);
    if (rec_q.size() > base) begin
      check_eq("rev_mask", 64'(rec_q[base].mask), 64'h3F);
      check_eq("rev_dac",  64'(rec_q[base].dac),  64'h200);
      check_eq("mm_cnt",   64'(rec_q[base].cnt),  64'd3);
      check_eq("mm_cerr",  64'(rec_q[base].cerr), 64'd1);
    end
    check_eq("mm_sticky_set", 64'(bus.ErrorSticky), 64'd1);
    @(negedge Clk) bus.ClearError = 1'b1;
    @(negedge Clk) bus.ClearError = 1'b0;
    check_eq("mm_sticky_clr", 64'(bus.ErrorSticky), 64'd0);

    // Zero-word step is a legal record.
    base = rec_q.size();
    bus.ExpectedCount = 16'd0;
    send(HDR, 1'b0);
    send(STP, 1'b0);
    send(16'h0001, 1'b0);
    send(TL, 1'b0);
    idle(3);
    check_eq("zero_nrec", 64'(rec_q.size() - base), 64'd1);
    if (rec_q.size() > base) begin
      check_eq("zero_cnt",  64'(rec_q[base].cnt),  64'd0);
      check_eq("zero_cerr", 64'(rec_q[base].cerr), 64'd0);
      check_eq("zero_dac",  64'(rec_q[base].dac),  64'h200);
    end

    // Framing violation: a marker where the parameter word belongs.
    base = rec_q.size();
    f0 = n_ferr;
    send(HDR, 1'b0);
    send(STP, 1'b0);
    send(STP, 1'b0);
    idle(3);
    check_eq("frm_ferr",   64'(n_ferr - f0), 64'd1);
    check_eq("frm_nrec",   64'(rec_q.size() - base), 64'd0);
    check_eq("frm_busy",   64'(bus.Busy), 64'd0);
    check_eq("frm_sticky", 64'(bus.ErrorSticky), 64'd1);
    clean_sweep("resync", 1'b0);

    // Reset in the middle of DATA after two words.
    base = rec_q.size();
    send(HDR, 1'b0);
    send(STP, 1'b0);
    send(sweep_params[0], 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    @(negedge Clk);
    bus.SweepData_en = 1'b0;
    reset_n = 1'b0;
    @(negedge Clk);
    check_eq("midrst_outputs",
             64'({bus.StepDAC0, bus.StepMask, bus.StepCount, bus.StepValid,
                  bus.StepCountError, bus.StepIndex, bus.SweepDone,
                  bus.FramingError, bus.ErrorSticky, bus.Busy}), 64'd0);
    reset_n = 1'b1;
    check_eq("midrst_nrec", 64'(rec_q.size() - base), 64'd0);
    clean_sweep("after_rst", 1'b0);

    check_eq("pulse_len_valid", 64'(max_v), 64'd1);
    check_eq("pulse_len_done",  64'(max_d), 64'd1);
    check_eq("pulse_len_ferr",  64'(max_f), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sweep_data_parser.md
# sweep_data_parser

Receive-side decoder for the framed 16-bit stream produced by the DAC0 sweep acquisition controller. The block sits on the host-bound path, after that controller's `SweepACQData`/`SweepACQData_en` output and before the USB FIFO and the on-board S-curve accumulator. For each DAC step it recovers the DAC0 code (restored from SC bit order to natural order), the channel mask and the number of data words. It emits one record per step and checks framing and package counts.

## Interface
Parameters:
- `HEADER_WORD`, 16'hFFAB: sweep start marker.
- `STEP_WORD`, 16'hFF5C: DAC-step start marker.
- `TAIL_WORD`, 16'hFF5D: sweep end marker.

Ports:
- `Clk`  in  1  system clock. The block uses this one clock only.
- `reset_n`  in  1  reset, synchronous and active-low.
- `SweepData`  in  16  stream word.
- `SweepData_en`  in  1  qualifies `SweepData` for one cycle.
- `ExpectedCount`  in  16  expected data words per step (MaxPackageNumber).
- `ClearError`  in  1  clears `ErrorSticky`.
- `StepDAC0`  out  10  DAC0 of the finished step, natural bit order.
- `StepMask`  out  6  mask channel of the finished step.
- `StepCount`  out  16  data words received in the finished step.
- `StepValid`  out  1  1-cycle pulse; record outputs are valid.
- `StepCountError`  out  1  valid with `StepValid`; asserted when `StepCount != ExpectedCount`.
- `StepIndex`  out  10  index of the finished step, starting at 0.
- `SweepDone`  out  1  1-cycle pulse on a correctly framed tail.
- `FramingError`  out  1  1-cycle pulse on any protocol violation.
- `ErrorSticky`  out  1  set by `FramingError` or `StepCountError`.
- `Busy`  out  1  high in every state other than IDLE.

## Operation
- A marker is any word with `SweepData[15:8]==8'hFF`. Data and parameter words never have 8'hFF in the top byte.
- The parameter word is `{MaskChannel[5:0], DAC0_SC[9:0]}`. `DAC0_SC` is bit-reversed, so `StepDAC0 = reverse(word[9:0])`.
- Only cycles with `SweepData_en=1` are processed. In all other cycles the FSM state and the counters hold.
- FSM transitions:
  - IDLE: HEADER goes to WAIT_STEP and clears `StepIndex`. All other words are silently discarded.
  - WAIT_STEP: STEP goes to PARAM. TAIL pulses `SweepDone` and goes to IDLE. Any other word is a framing error.
  - PARAM: a non-marker word latches DAC and mask, clears the word counter and goes to DATA. A marker is a framing error.
  - DATA: a non-marker word increments the counter. The counter saturates at 16'hFFFF.
  - DATA, STEP word: emit the record, increment `StepIndex`, go to PARAM.
  - DATA, TAIL word: emit the record, pulse `SweepDone`, go to IDLE. `StepValid` and `SweepDone` pulse in the same cycle.
  - DATA, HEADER or unknown marker: framing error.
- On a framing error: pulse `FramingError`, set `ErrorSticky`, discard the partial step (no `StepValid`), go to IDLE. The block resynchronises on the next HEADER.
- A step with zero data words is legal. It emits a record with `StepCount=0`.
- `StepIndex` wraps from 1023 to 0.
- `ErrorSticky` is cleared by `ClearError` or by a HEADER accepted in IDLE. If a set condition occurs in the same cycle, set wins.
- Mid-operation reset: return to IDLE, drive all outputs to 0, discard the partial step.

## Timing
- All outputs are registered. A word accepted at edge N produces its pulses and record at edge N+1.
- Record outputs hold their value until the next `StepValid`.
- Pulses last exactly 1 cycle, even when `SweepData_en` is held high.
- Throughput is one word per cycle with back-to-back `SweepData_en`. There is no backpressure, and the downstream must accept a record every cycle.
- Reset values are 0 on every output. The FSM resets to IDLE.

## Structure
- A shared package holds the marker constants, the FSM state encoding (IDLE, WAIT_STEP, PARAM, DATA) and the `dac_invert` bit-reverse function. The sweep acquisition controller uses the same function, so transmitter and receiver share one definition.
- One sub-module: `sweep_step_counter`, the saturating 16-bit word counter with clear/increment and compare-to-`ExpectedCount`.

## Test plan
- Clean sweep: HEADER, then 3 steps with DAC_SC for 100/101/102 and `ExpectedCount=4`, 4 data words each, then TAIL. Require 3 `StepValid` pulses with `StepDAC0`=100/101/102, `StepCount=4`, `StepCountError=0`, `StepIndex` 0/1/2, `SweepDone` once, `ErrorSticky=0`.
- Bit reverse: parameter word 16'hFC01. Require `StepMask=6'h3F`, `StepDAC0=10'h200`.
- Count mismatch: 3 words with `ExpectedCount=4`. Require `StepCount=3`, `StepCountError=1`, `ErrorSticky=1`. Then `ClearError` returns `ErrorSticky` to 0.
- Framing: HEADER, STEP, STEP. Require `FramingError` pulse, no `StepValid`, IDLE. A following clean sweep parses correctly.
- Gapped enable: clean sweep with `SweepData_en` low on random cycles. Results must be identical to the back-to-back run, and no pulse may be longer than 1 cycle.
- Reset mid-DATA after 2 words: all outputs 0. The next sweep parses correctly from `StepIndex=0`.
